// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller.
// State enum, opcodes, datapath mux selects and small decode helpers.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic state_t decode_next(input logic [6:0] op);
        state_t nxt;
        unique case (op)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_RTYPE:     nxt = S_EXECUTER;
            OP_ITYPE:     nxt = S_EXECUTEI;
            OP_BEQ:       nxt = S_BEQ;
            OP_JAL:       nxt = S_JAL;
            default:      nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

    function automatic logic [1:0] imm_format(input logic [6:0] op);
        logic [1:0] fmt;
        unique case (op)
            OP_SW:   fmt = IMM_S;
            OP_BEQ:  fmt = IMM_B;
            OP_JAL:  fmt = IMM_J;
            default: fmt = IMM_I;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's aluop plus funct fields onto an ALU operation.
// Subtract in funct mode only for R-type (op[5]) with funct7[5] set.
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] aluop,
    output logic [2:0] alucontrol
);

    logic [2:0] funct_op;

    always_comb begin
        funct_op = ALU_ADD;
        unique case (funct3)
            3'b000:  funct_op = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_op = ALU_SLT;
            3'b110:  funct_op = ALU_OR;
            3'b111:  funct_op = ALU_AND;
            default: funct_op = ALU_ADD;
        endcase
    end

    always_comb begin
        alucontrol = ALU_ADD;
        unique case (aluop)
            ALUOP_ADD:   alucontrol = ALU_ADD;
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_FUNCT: alucontrol = funct_op;
            default:     alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V controller: Moore FSM sequencing the shared datapath,
// with memory-ready stalls and a sticky illegal-opcode trap state.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter bit RESET_STATE_FETCH = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       adrsrc,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] immsrc,
    output logic [2:0] alucontrol,
    output logic       instr_done,
    output logic       illegal_instr
);

    // Only FETCH is a supported reset target.
    localparam state_t RESET_STATE = RESET_STATE_FETCH ? S_FETCH : S_FETCH;

    state_t     state;
    logic [1:0] aluop;
    logic       pcupdate;
    logic       branch;
    logic       ir_load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RESET_STATE;
        end else begin
            unique case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE:   state <= decode_next(op);
                S_MEMADR:   state <= op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (mem_ready) state <= S_FETCH;
                S_EXECUTER: state <= S_ALUWB;
                S_EXECUTEI: state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BEQ:      state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                S_TRAP:     state <= S_TRAP;
                default:    state <= S_TRAP;
            endcase
        end
    end

    always_comb begin
        mem_req       = 1'b0;
        memwrite      = 1'b0;
        adrsrc        = 1'b0;
        ir_load       = 1'b0;
        pcupdate      = 1'b0;
        branch        = 1'b0;
        regwrite      = 1'b0;
        resultsrc     = RES_ALUOUT;
        alusrca       = SRCA_PC;
        alusrcb       = SRCB_RS2;
        aluop         = ALUOP_ADD;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        unique case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alusrca   = SRCA_PC;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALURESULT;
                ir_load   = mem_ready;
                pcupdate  = mem_ready;
            end
            S_DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
            end
            S_MEMADR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adrsrc  = 1'b1;
            end
            S_MEMWB: begin
                resultsrc  = RES_DATA;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                memwrite   = 1'b1;
                adrsrc     = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTER: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_RS2;
                aluop   = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                resultsrc  = RES_ALUOUT;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                alusrca    = SRCA_RS1;
                alusrcb    = SRCB_RS2;
                aluop      = ALUOP_SUB;
                resultsrc  = RES_ALUOUT;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                alusrca   = SRCA_OLDPC;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALUOUT;
                pcupdate  = 1'b1;
            end
            S_TRAP: begin
                illegal_instr = 1'b1;
            end
            default: begin
                illegal_instr = 1'b1;
            end
        endcase
    end

    // Qualify the ready-driven enables so nothing is written while in reset.
    assign irwrite = reset_n & ir_load;
    assign pcwrite = reset_n & (pcupdate | (branch & zero));
    assign immsrc  = (reset_n && state != S_TRAP) ? imm_format(op) : IMM_I;

    alu_decoder u_alu_decoder (
        .opb5       (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .aluop      (aluop),
        .alucontrol (alucontrol)
    );

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Controller for the multicycle RISC-V core.
- Sequences the shared datapath (single ALU, unified memory port, instruction register) through fetch/decode/execute/writeback states.
- Supports lw, sw, R-type, I-type ALU, beq and jal.
- Adds a memory ready handshake so slow memories stall the FSM, and a sticky illegal-opcode trap.
- Sits between the instruction register/ALU flags and every datapath mux and enable.

Parameters:
- RESET_STATE_FETCH, 1, reserved; must stay 1. Reset always enters FETCH.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- op  in  7  instruction opcode (IR[6:0])
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- memwrite  out  1  write qualifier for mem_req
- adrsrc  out  1  address select: 0 = PC, 1 = ALUOut
- irwrite  out  1  load IR and OldPC
- pcwrite  out  1  PC enable
- regwrite  out  1  register file write enable
- resultsrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
- alusrca  out  2  ALU A mux: 00 = PC, 01 = OldPC, 10 = rs1
- alusrcb  out  2  ALU B mux: 00 = rs2, 01 = imm, 10 = constant 4
- immsrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- alucontrol  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal_instr  out  1  sticky trap flag

Behaviour:
- Clock and reset: one clock domain. Asynchronous active-low reset forces state to FETCH and clears illegal_instr.
- Output style: all outputs are combinational from state (Moore), except these terms:
  - irwrite, pcwrite and instr_done depend on mem_ready/zero.
  - immsrc depends on op.
  - alucontrol depends on funct3 and funct7b5.
- Outputs during reset equal the FETCH decode: mem_req=1, adrsrc=0, alusrca=00, alusrcb=10, resultsrc=10, alucontrol=000. All other outputs are 0.
- Internal aluop:
  - 00 gives add.
  - 01 gives sub.
  - 10 decodes funct3: 000 gives add, or sub when op[5]&funct7b5; 010 gives slt; 110 gives or; 111 gives and; any other funct3 gives add.
- pcwrite = pcupdate | (branch & zero).
- Defaults: any output not listed for a state is 0.
- States and outputs:
  - FETCH: mem_req, A=PC, B=4, add, resultsrc=10. When mem_ready: irwrite=1, pcupdate=1, go to DECODE. Otherwise hold, with irwrite=0 and pcwrite=0.
  - DECODE: A=OldPC, B=imm, add (precomputes branch/jump target). Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - anything else → TRAP
  - MEMADR: A=rs1, B=imm, add. Go to MEMREAD if op[5]=0, otherwise MEMWRITE.
  - MEMREAD: mem_req, adrsrc=1. Hold until mem_ready, then go to MEMWB.
  - MEMWB: resultsrc=01, regwrite, instr_done. Go to FETCH.
  - MEMWRITE: mem_req, memwrite, adrsrc=1. Hold until mem_ready, then pulse instr_done and go to FETCH.
  - EXECUTER: A=rs1, B=rs2, aluop=10. Go to ALUWB.
  - EXECUTEI: A=rs1, B=imm, aluop=10. Go to ALUWB.
  - ALUWB: resultsrc=00, regwrite, instr_done. Go to FETCH.
  - BEQ: A=rs1, B=rs2, sub, resultsrc=00, branch=1, instr_done. Go to FETCH.
  - JAL: A=OldPC, B=4, add, resultsrc=00, pcupdate=1. Go to ALUWB.
  - TRAP: illegal_instr=1, all other outputs 0. Stays in TRAP until reset.
- immsrc decode by op: sw → 01, beq → 10, jal → 11, otherwise 00.
- Latency with mem_ready tied to 1: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq 3 cycles.
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. No output may change while stalled.
- mem_ready outside the three access states is ignored.
- Reset asserted mid-instruction aborts immediately. No partial regwrite or memwrite occurs after reset_n falls.

Decomposition:
- Shared package: state enum, opcode constants, and the aluop, alucontrol, resultsrc, alusrca, alusrcb and immsrc encodings.
- Sub-module: reuse the existing alu_decoder for the aluop→alucontrol mapping (ports opb5, funct3, funct7b5, aluop). The FSM stays in this module.

Test Plan:
- lw (op 0000011), mem_ready=1 → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. regwrite=1 with resultsrc=01 only in cycle 5. instr_done pulses once.
- sw with mem_ready low 3 cycles in MEMWRITE → memwrite and mem_req held for 4 cycles with adrsrc=1. instr_done fires on the ready cycle. regwrite never asserts.
- R-type sub (funct3=000, funct7b5=1) → alucontrol=001 in EXECUTER. ALUWB asserts regwrite. 4 cycles total.
- beq with zero=1 → pcwrite=1 in the BEQ cycle. Repeat with zero=0 → pcwrite=0. Both take 3 cycles.
- FETCH with mem_ready=0 for 2 cycles → irwrite=0 and pcwrite=0 while stalled. Both pulse in the same cycle once ready.
- op=1111111 → TRAP after DECODE, illegal_instr=1 and sticky. reset_n low mid-TRAP → FETCH and flag cleared asynchronously.
